// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: command front end for an external LFSR.
//
// Byte-wide commands load the tap and seed registers of the LFSR, start
// it (RUN) and stop it (HALT). While running, every LFSR advance is
// captured into a one-entry sample stream. A sample that is replaced
// before it was taken sets the sticky overrun_o flag.
//
// Handshakes (cmd_* and sample_*): a transfer happens on a rising clk
// edge where valid and ready are both high. The producer holds its data
// stable while valid is high and ready is low.
//
// Ports
//   clk, rst_i                 clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o    command handshake
//   cmd_op_i                   0=LOAD_TAPS 1=LOAD_SEED 2=RUN 3=HALT
//   cmd_data_i                 byte for LOAD_TAPS / LOAD_SEED
//   lfsr_reset_taps_o, lfsr_taps_o   tap load strobe and value
//   lfsr_reset_o, lfsr_seed_o        LFSR reset and initial state
//   lfsr_state_i               current LFSR state
//   sample_valid_o/sample_ready_i/sample_o   advanced-state stream
//   running_o                  controller is in run mode
//   overrun_o                  sticky sample-lost flag
//   dbg_state_o                FSM state, for observation only
//
// Optional feature (macro LFSR_CTRL_PERIOD_EN): period_o/period_valid_o
// report the number of advances until the sequence first returns to the
// seed value.
module lfsr_ctrl #(
  parameter int BITS  = 8,
  parameter int TICKS = 1
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [7:0]      cmd_data_i,
  output logic            lfsr_reset_taps_o,
  output logic [BITS-1:0] lfsr_taps_o,
  output logic            lfsr_reset_o,
  output logic [BITS-1:0] lfsr_seed_o,
  input  logic [BITS-1:0] lfsr_state_i,
  output logic            sample_valid_o,
  input  logic            sample_ready_i,
  output logic [BITS-1:0] sample_o,
  output logic            running_o,
  output logic            overrun_o,
  output logic [1:0]      dbg_state_o
`ifdef LFSR_CTRL_PERIOD_EN
  ,
  output logic [BITS-1:0] period_o,
  output logic            period_valid_o
`endif
);

  localparam int BYTES = BITS / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS - 1);

  localparam logic [1:0] ST_HALT       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_APPLY_TAPS = 2'd2;
  localparam logic [1:0] ST_APPLY_SEED = 2'd3;

  localparam logic [1:0] OP_LOAD_TAPS = 2'd0;
  localparam logic [1:0] OP_LOAD_SEED = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_HALT      = 2'd3;

  logic [1:0]      state;
  logic            ret_run;      // APPLY_* was entered from RUN
  logic [BITS-1:0] taps_shadow;
  logic [BITS-1:0] seed_shadow;
  logic [CW-1:0]   taps_cnt;
  logic [CW-1:0]   seed_cnt;
  logic [TW-1:0]   tick_cnt;
  logic            adv_d;        // an LFSR advance happened on the last edge
  logic            in_apply;
  logic            cmd_fire;
  logic            advance;
  logic            sample_load;
  logic [BITS-1:0] data_ext;
  logic [BITS-1:0] taps_next;
  logic [BITS-1:0] seed_next;

  assign data_ext  = BITS'(cmd_data_i);
  assign taps_next = (taps_shadow << 8) | data_ext;
  assign seed_next = (seed_shadow << 8) | data_ext;

  assign in_apply          = (state == ST_APPLY_TAPS) || (state == ST_APPLY_SEED);
  assign cmd_ready_o       = !in_apply;
  assign cmd_fire          = cmd_valid_i && cmd_ready_o;
  assign lfsr_reset_taps_o = (state == ST_APPLY_TAPS);
  // A tap update while halted keeps the LFSR parked in reset.
  assign lfsr_reset_o      = (state == ST_HALT) || (state == ST_APPLY_SEED) ||
                             ((state == ST_APPLY_TAPS) && !ret_run);
  assign running_o         = (state == ST_RUN) || (in_apply && ret_run);
  assign dbg_state_o       = state;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_HALT;
      ret_run     <= 1'b0;
      taps_shadow <= '0;
      seed_shadow <= '0;
      taps_cnt    <= '0;
      seed_cnt    <= '0;
      lfsr_taps_o <= '0;
      lfsr_seed_o <= '0;
    end else begin
      case (state)
        ST_HALT, ST_RUN: begin
          if (cmd_fire) begin
            case (cmd_op_i)
              OP_LOAD_TAPS: begin
                taps_shadow <= taps_next;
                if (taps_cnt == LAST_BYTE) begin
                  taps_cnt    <= '0;
                  lfsr_taps_o <= taps_next;
                  ret_run     <= (state == ST_RUN);
                  state       <= ST_APPLY_TAPS;
                end else begin
                  taps_cnt <= taps_cnt + 1'b1;
                end
              end
              OP_LOAD_SEED: begin
                seed_shadow <= seed_next;
                if (seed_cnt == LAST_BYTE) begin
                  seed_cnt    <= '0;
                  lfsr_seed_o <= seed_next;
                  ret_run     <= (state == ST_RUN);
                  state       <= ST_APPLY_SEED;
                end else begin
                  seed_cnt <= seed_cnt + 1'b1;
                end
              end
              OP_RUN:  state <= ST_RUN;
              OP_HALT: state <= ST_HALT;
              default: state <= state;
            endcase
          end
        end
        default: state <= ret_run ? ST_RUN : ST_HALT;
      endcase
    end
  end

  // Mirror of the LFSR's own tick counter so we know when it advances.
  assign advance = !lfsr_reset_o && !lfsr_reset_taps_o && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
      adv_d    <= 1'b0;
    end else begin
      adv_d <= advance;
      if (lfsr_reset_o) begin
        tick_cnt <= '0;
      end else if (!lfsr_reset_taps_o) begin
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
      end
    end
  end

  // The advanced state is visible on lfsr_state_i one cycle after the
  // advance. A seed reload or halt in that cycle discards it.
  assign sample_load = adv_d && !lfsr_reset_o;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      if (sample_load) begin
        sample_o       <= lfsr_state_i;
        sample_valid_o <= 1'b1;
      end else if (sample_valid_o && sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end
      if (state == ST_APPLY_SEED) begin
        overrun_o <= 1'b0;
      end else if (sample_load && sample_valid_o && !sample_ready_i) begin
        overrun_o <= 1'b1;
      end
    end
  end

`ifdef LFSR_CTRL_PERIOD_EN
  logic [BITS-1:0] adv_cnt;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      adv_cnt        <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else if (lfsr_reset_o) begin
      adv_cnt        <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      if (advance && (adv_cnt != '1)) begin
        adv_cnt <= adv_cnt + 1'b1;
      end
      // adv_cnt already includes the advance that produced lfsr_state_i.
      if (adv_d && !period_valid_o && (lfsr_state_i == lfsr_seed_o)) begin
        period_o       <= adv_cnt;
        period_valid_o <= 1'b1;
      end
    end
  end
`endif

endmodule
